// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT parameter sets and index helpers
package ntt_pkg;
    localparam int KYBER_N         = 256;
    localparam int KYBER_WIDTH     = 12;
    localparam int DILITHIUM_N     = 256;
    localparam int DILITHIUM_WIDTH = 23;
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) r[i] = x[bits-1-i];
        return r;
    endfunction
endpackage

// File: rtl/reorder_mem.sv
// reorder_mem: two-bank coefficient store, synchronous write and asynchronous read
module reorder_mem #(
    parameter int WIDTH = 23,
    parameter int N     = 256,
    parameter int AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             wr_bank_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_bank_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);
    logic [WIDTH-1:0] mem_q [2*N];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
    assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];
endmodule

// File: rtl/reorder_buf.sv
// reorder_buf: ping-pong buffer turning bit-reversed NTT output into natural order
module reorder_buf
    import ntt_pkg::*;
#(
    parameter int WIDTH  = DILITHIUM_WIDTH,
    parameter int N      = DILITHIUM_N,
    parameter bit BITREV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);
    localparam int AW = $clog2(N);
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, wr_addr;
    logic [1:0]    full_q, full_d;
    logic          wr_en, rd_en, wr_wrap, rd_wrap;
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_last  = out_valid && rd_cnt_q == AW'(N-1);
    assign wr_addr   = BITREV ? AW'(bitrev(32'(wr_cnt_q), AW)) : wr_cnt_q;
    // Set and clear can coincide only on opposite banks, so both are applied.
    always_comb begin
        wr_en     = in_valid && in_ready;
        rd_en     = out_valid && out_ready;
        wr_wrap   = wr_en && wr_cnt_q == AW'(N-1);
        rd_wrap   = rd_en && rd_cnt_q == AW'(N-1);
        wr_cnt_d  = wr_en ? wr_cnt_q + AW'(1) : wr_cnt_q;
        rd_cnt_d  = rd_en ? rd_cnt_q + AW'(1) : rd_cnt_q;
        wr_bank_d = wr_bank_q ^ wr_wrap;
        rd_bank_d = rd_bank_q ^ rd_wrap;
        full_d    = full_q;
        if (wr_wrap) full_d[wr_bank_q] = 1'b1;
        if (rd_wrap) full_d[rd_bank_q] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= 2'b00;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
        end
    end
    reorder_mem #(.WIDTH(WIDTH), .N(N), .AW(AW)) u_mem (
        .clk       (clk),
        .we_i      (wr_en),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (in_data),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (out_data)
    );
endmodule

// File: tb/tb_reorder_buf.sv
// tb_reorder_buf: vector table, directed corner sequences and a queue-based random scoreboard
module tb_reorder_buf;
    localparam int W  = 23;
    localparam int N  = 8;
    localparam int BN = 256;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic br_in_ready, br_out_valid, br_out_last, nat_in_ready, nat_out_valid, nat_out_last;
    logic [W-1:0] br_out_data, nat_out_data;
    logic b_in_valid = 1'b0, b_out_ready = 1'b0, b_in_ready, b_out_valid, b_out_last;
    logic [W-1:0] b_in_data = '0, b_out_data;
    int checks = 0, errors = 0, nreads = 0;
    logic [W-1:0] pend[$], exp_br[$], exp_nat[$];
    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         e_rdy;
        logic         e_ov;
        logic         e_last;
        logic [W-1:0] e_br;
        logic [W-1:0] e_nat;
    } vec_t;
    vec_t tbl[17];

    always #5 clk = ~clk;

    reorder_buf #(.WIDTH(W), .N(N), .BITREV(1'b1)) u_br (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(br_in_ready), .in_data(in_data),
        .out_valid(br_out_valid), .out_ready(out_ready), .out_data(br_out_data), .out_last(br_out_last));
    reorder_buf #(.WIDTH(W), .N(N), .BITREV(1'b0)) u_nat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nat_in_ready), .in_data(in_data),
        .out_valid(nat_out_valid), .out_ready(out_ready), .out_data(nat_out_data), .out_last(nat_out_last));
    reorder_buf #(.WIDTH(W), .N(BN), .BITREV(1'b1)) u_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last));

    function automatic int tb_rev(input int x, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic iv, input int d, input logic ordy, input logic e_rdy,
                                input logic e_ov, input logic e_last, input int e_br, input int e_nat);
        vec_t v;
        v.iv = iv; v.d = W'(d); v.ordy = ordy; v.e_rdy = e_rdy;
        v.e_ov = e_ov; v.e_last = e_last; v.e_br = W'(e_br); v.e_nat = W'(e_nat);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle against the queue model: outputs checked at negedge, model advanced after posedge.
    task automatic tick();
        int rem;
        logic wf, rf;
        @(negedge clk);
        rem = (exp_br.size() + N - 1) / N;
        chk("br_in_ready", 32'(br_in_ready), 32'(rem < 2));
        chk("nat_in_ready", 32'(nat_in_ready), 32'(rem < 2));
        chk("br_out_valid", 32'(br_out_valid), 32'(exp_br.size() > 0));
        chk("nat_out_valid", 32'(nat_out_valid), 32'(exp_br.size() > 0));
        chk("br_out_last", 32'(br_out_last), 32'(exp_br.size() % N == 1));
        chk("nat_out_last", 32'(nat_out_last), 32'(exp_br.size() % N == 1));
        if (exp_br.size() > 0) begin
            chk("br_out_data", 32'(br_out_data), 32'(exp_br[0]));
            chk("nat_out_data", 32'(nat_out_data), 32'(exp_nat[0]));
        end
        wf = in_valid && rem < 2;
        rf = out_ready && exp_br.size() > 0;
        @(posedge clk);
        #1;
        if (rf) begin
            void'(exp_br.pop_front());
            void'(exp_nat.pop_front());
            nreads++;
        end
        if (wf) begin
            pend.push_back(in_data);
            if (pend.size() == N) begin
                for (int j = 0; j < N; j++) begin
                    exp_br.push_back(pend[tb_rev(j, $clog2(N))]);
                    exp_nat.push_back(pend[j]);
                end
                pend.delete();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int br_seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        logic [W-1:0] held;
        int target, cyc, r;
        for (int i = 0; i < 8; i++) tbl[i] = mk(1'b1, i, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        for (int j = 0; j < 8; j++) tbl[8+j] = mk(1'b0, 0, 1'b1, 1'b1, 1'b1, j == 7, br_seq[j], j);
        tbl[16] = mk(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(br_in_ready), 32'(1));
        chk("rst_out_valid", 32'(br_out_valid), 32'(0));
        chk("rst_out_last", 32'(br_out_last), 32'(0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk("tbl_in_ready", 32'(br_in_ready), 32'(tbl[i].e_rdy));
            chk("tbl_nat_in_ready", 32'(nat_in_ready), 32'(tbl[i].e_rdy));
            chk("tbl_out_valid", 32'(br_out_valid), 32'(tbl[i].e_ov));
            chk("tbl_nat_out_valid", 32'(nat_out_valid), 32'(tbl[i].e_ov));
            chk("tbl_out_last", 32'(br_out_last), 32'(tbl[i].e_last));
            if (tbl[i].e_ov) begin
                chk("tbl_br_data", 32'(br_out_data), 32'(tbl[i].e_br));
                chk("tbl_nat_data", 32'(nat_out_data), 32'(tbl[i].e_nat));
            end
            @(posedge clk);
            #1;
        end

        // Backpressure: both banks fill, extra offers are held off, output stays stable.
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 2 * N + 3; i++) begin
            in_data = W'(100 + i);
            tick();
        end
        chk("bp_in_ready_low", 32'(br_in_ready), 32'(0));
        held = br_out_data;
        tick();
        tick();
        chk("bp_data_stable", 32'(br_out_data), 32'(held));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < N - 1; i++) tick();
        chk("bp_in_ready_before_last", 32'(br_in_ready), 32'(0));
        tick();
        chk("bp_in_ready_after_last", 32'(br_in_ready), 32'(1));
        for (int i = 0; i < N + 1; i++) tick();

        // Reset mid-stream with one full bank and a partial one.
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < N + N / 2; i++) begin
            in_data = W'($urandom);
            tick();
        end
        rst = 1'b1;
        #2;
        chk("arst_in_ready", 32'(br_in_ready), 32'(1));
        chk("arst_out_valid", 32'(br_out_valid), 32'(0));
        chk("arst_out_last", 32'(br_out_last), 32'(0));
        pend.delete(); exp_br.delete(); exp_nat.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Final write of bank 1 coincides with final read of bank 0.
        for (int i = 0; i < N; i++) begin
            in_data = W'(200 + i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_data = W'(300 + i);
            tick();
        end
        chk("sim_out_valid", 32'(br_out_valid), 32'(1));
        chk("sim_in_ready", 32'(br_in_ready), 32'(1));
        in_valid = 1'b0;
        for (int i = 0; i < N + 1; i++) tick();

        // Random traffic, 30% idle on each side, 20 polynomials.
        target = nreads + 20 * N;
        cyc = 0;
        while (nreads < target && cyc < 20 * N * 8) begin
            in_valid = $urandom_range(9) >= 3;
            out_ready = $urandom_range(9) >= 3;
            in_data = W'($urandom);
            tick();
            cyc++;
        end
        chk("random_reads_done", 32'(nreads), 32'(target));
        in_valid = 1'b0; out_ready = 1'b0;

        // Back-to-back stream of four full-size polynomials.
        for (int c = 0; c < 5 * BN; c++) begin
            b_in_valid = c < 4 * BN; b_in_data = W'(c); b_out_ready = 1'b1;
            @(negedge clk);
            chk("big_in_ready", 32'(b_in_ready), 32'(1));
            chk("big_out_valid", 32'(b_out_valid), 32'(c >= BN));
            if (c >= BN) begin
                r = c - BN;
                chk("big_out_data", 32'(b_out_data), 32'(tb_rev(r % BN, 8) + BN * (r / BN)));
                chk("big_out_last", 32'(b_out_last), 32'(r % BN == BN - 1));
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("big_drained", 32'(b_out_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
